ws2812_frame_transmitter: RTL

- Consumer end of the activity/refresh pulse. The start pulse comes from the activity detector: a player-button edge or the one-shot boot pulse.
- On start, fetches one 24-bit GRB word per LED from the track colour logic over an index/data lookup interface.
- Serialises each word onto the single-wire WS2812 data line with cycle-exact high/low timing, then holds the line low for the latch gap.
- Start pulses arriving during a frame are coalesced into exactly one follow-up frame, so the last state change always reaches the strip.

---
 rtl/ws2812_pkg.sv | 22 ++
 rtl/ws2812_bit_encoder.sv | 52 +++++
 rtl/ws2812_frame_transmitter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared timing defaults, state encoding and sizing helper for the WS2812 transmitter.
package ws2812_pkg;

  localparam int GRB_W       = 24;
  localparam int DEF_T0H     = 20;
  localparam int DEF_T1H     = 40;
  localparam int DEF_T_BIT   = 63;
  localparam int DEF_T_RESET = 2500;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_LATCH
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Produces one WS2812 bit waveform per go strobe: high for T0H/T1H cycles, low for the rest of T_BIT.
module ws2812_bit_encoder
  import ws2812_pkg::*;
#(
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H,
  parameter int T_BIT = DEF_T_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int PW = cnt_w(T_BIT);
  localparam logic [PW-1:0] LAST_PH = PW'(T_BIT - 1);
  localparam logic [PW-1:0] T0H_M1  = PW'(T0H - 1);
  localparam logic [PW-1:0] T1H_M1  = PW'(T1H - 1);

  logic [PW-1:0] phase;
  logic          active;
  logic          val;

  // Last cycle of the current bit; a go in this cycle starts the next bit seamlessly.
  assign bit_done = active && (phase == LAST_PH);

  // Phase counter and registered line level; dout for phase k+1 is decided while at phase k.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      phase  <= '0;
      val    <= 1'b0;
      dout   <= 1'b0;
    end else if (go) begin
      active <= 1'b1;
      phase  <= '0;
      val    <= bit_val;
      dout   <= 1'b1;
    end else if (active) begin
      if (bit_done) begin
        active <= 1'b0;
        dout   <= 1'b0;
      end else begin
        phase <= phase + 1'b1;
        dout  <= phase < (val ? T1H_M1 : T0H_M1);
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_transmitter.sv
// Fetches one GRB word per LED and streams the chain onto the WS2812 line, then holds the latch gap.
module ws2812_frame_transmitter
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = 100,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T_RESET  = DEF_T_RESET,
  parameter int IDX_W    = cnt_w(NUM_LEDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [GRB_W-1:0] grb_in,
  output logic [IDX_W-1:0] led_index,
  output logic             busy,
  output logic             dout
);

  localparam int GAP_W = cnt_w(T_RESET + 1);
  localparam int BIT_W = cnt_w(GRB_W);
  localparam logic [IDX_W-1:0] LAST_LED = IDX_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(GRB_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_RESET - 1);

  state_t             state, state_nxt;
  logic               fetch_ph;   // 0 = first FETCH cycle, 1 = second
  logic [BIT_W-1:0]   bit_cnt;    // bit currently on the line, 23 down to 0
  logic [IDX_W-1:0]   led_cnt;    // LED currently on the line
  logic [GRB_W-2:0]   shift;      // bits still to send for the current LED
  logic [GAP_W-1:0]   gap;
  logic               pending;
  logic               enc_go;
  logic               enc_bit;
  logic               bit_done;
  logic               gap_end;

  assign gap_end = (state == ST_LATCH) && (gap == '0);

  ws2812_bit_encoder #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT)
  ) u_enc (
    .clk      (clk),
    .reset    (reset),
    .go       (enc_go),
    .bit_val  (enc_bit),
    .dout     (dout),
    .bit_done (bit_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and encoder strobes. The next LED's word is on grb_in from the second cycle
  // of bit 0 (index advanced at its first cycle), so it is taken straight at the boundary.
  always_comb begin
    state_nxt = state;
    enc_go    = 1'b0;
    enc_bit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_ph) begin
          state_nxt = ST_SEND;
          enc_go    = 1'b1;
          enc_bit   = grb_in[GRB_W-1];
        end
      end
      ST_SEND: begin
        if (bit_done) begin
          if (bit_cnt != '0) begin
            enc_go  = 1'b1;
            enc_bit = shift[GRB_W-2];
          end else if (led_cnt != LAST_LED) begin
            enc_go  = 1'b1;
            enc_bit = grb_in[GRB_W-1];
          end else begin
            state_nxt = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        if (gap_end) state_nxt = (pending || start) ? ST_FETCH : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bit/LED counters, prefetch index, latch gap, busy and the coalescing request flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_ph  <= 1'b0;
      bit_cnt   <= '0;
      led_cnt   <= '0;
      led_index <= '0;
      shift     <= '0;
      gap       <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: begin
          fetch_ph  <= 1'b0;
          led_cnt   <= '0;
          led_index <= '0;
        end
        ST_FETCH: begin
          fetch_ph <= ~fetch_ph;
          if (fetch_ph) begin
            shift   <= grb_in[GRB_W-2:0];
            bit_cnt <= TOP_BIT;
            led_cnt <= '0;
          end
        end
        ST_SEND: begin
          if (bit_done) begin
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              shift   <= {shift[GRB_W-3:0], 1'b0};
              // Entering bit 0: point the colour lookup at the next LED.
              if (bit_cnt == BIT_W'(1) && led_cnt != LAST_LED) led_index <= led_cnt + 1'b1;
            end else if (led_cnt != LAST_LED) begin
              shift   <= grb_in[GRB_W-2:0];
              bit_cnt <= TOP_BIT;
              led_cnt <= led_cnt + 1'b1;
            end else begin
              led_cnt   <= '0;
              led_index <= '0;
              gap       <= GAP_LAST;
            end
          end
        end
        ST_LATCH: begin
          if (gap != '0) gap <= gap - 1'b1;
        end
        default: ;
      endcase
      // The last latch cycle consumes the request itself; any earlier one is remembered once.
      if (gap_end)                        pending <= 1'b0;
      else if (state != ST_IDLE && start) pending <= 1'b1;
    end
  end

endmodule
